// File: rtl/fp_addsub_pipe_if.sv
// Handshake bundle for the pipelined FP adder/subtractor: operand side plus result side.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         ovf;
  logic         unf;

  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, c, ovf, unf);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, c, ovf, unf);
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage FP add/sub (align, add+normalise, round RNE) with FTZ, valid/ready and whole-pipe stall.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  fp_addsub_pipe_if.slave  bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int N      = MAN_W + 4;   // hidden, fraction, G, R, S
  localparam int M      = MAN_W + 3;   // hidden, fraction, G, R
  localparam int SHW    = $clog2(N);
  localparam int LZW    = $clog2(N + 1);
  localparam int EW     = EXP_W + 2;
  localparam int STAGES = 3;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  logic [STAGES:1] vld_pipe;
  logic            adv, fire;

  assign adv          = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign fire         = bus.in_valid & adv;

  // ---- stage 1: align ----
  logic               sa, sb, a_big, eff_sub;
  logic [EXP_W-1:0]   ea, eb, e_big, diff;
  logic [MAN_W-1:0]   fa, fb;
  logic [M-1:0]       ma, mb;
  logic [SHW-1:0]     sh;
  logic [2*M-1:0]     sml_wide;
  logic [N-1:0]       big_n, sml_n;

  always_comb begin
    sa      = bus.a[W-1];
    sb      = bus.b[W-1] ^ bus.op;
    ea      = bus.a[W-2:MAN_W];
    eb      = bus.b[W-2:MAN_W];
    fa      = bus.a[MAN_W-1:0];
    fb      = bus.b[MAN_W-1:0];
    ma      = (ea == '0) ? '0 : {1'b1, fa, 2'b00};
    mb      = (eb == '0) ? '0 : {1'b1, fb, 2'b00};
    a_big   = {ea, fa} >= {eb, fb};
    e_big   = a_big ? ea : eb;
    diff    = a_big ? ea - eb : eb - ea;
    sh      = (diff > EXP_W'(M)) ? SHW'(M) : SHW'(diff);
    // lower half collects everything shifted past R; it collapses to sticky
    sml_wide = {(a_big ? mb : ma), {M{1'b0}}} >> sh;
    big_n   = {(a_big ? ma : mb), 1'b0};
    sml_n   = {sml_wide[2*M-1:M], |sml_wide[M-1:0]};
    eff_sub = sa ^ sb;
  end

  logic             s1_sign, s1_sub, s1_zero, s1_zsign;
  logic [EXP_W-1:0] s1_exp;
  logic [N-1:0]     s1_big, s1_sml;

  // ---- stage 2: add/sub and normalise ----
  logic [N:0]            sum;
  logic [LZW-1:0]        lzc;
  logic [N-1:0]          norm;
  logic [EW-1:0]         e_ext;
  logic signed [EW-1:0]  e_norm;
  logic                  cancel;

  always_comb begin
    sum    = s1_sub ? {1'b0, s1_big} - {1'b0, s1_sml} : {1'b0, s1_big} + {1'b0, s1_sml};
    lzc    = LZW'(N);
    for (int i = 0; i < N; i++)
      if (sum[i]) lzc = LZW'(N - 1 - i);
    cancel = (sum == '0);
    e_ext  = {2'b00, s1_exp};
    if (sum[N]) begin
      norm   = {sum[N:2], sum[1] | sum[0]};
      e_norm = e_ext + EW'(1);
    end else begin
      norm   = sum[N-1:0] << lzc;
      e_norm = e_ext - EW'(lzc);
    end
  end

  logic                 s2_sign, s2_zero, s2_zsign, s2_cancel;
  logic signed [EW-1:0] s2_exp;
  logic [N-1:0]         s2_man;

  // ---- stage 3: round to nearest even, range checks ----
  logic                 inc, ovf_n, unf_n;
  logic [MAN_W:0]       frac_r;
  logic signed [EW-1:0] e_fin;
  logic [W-1:0]         c_n;

  always_comb begin
    inc    = s2_man[2] & (s2_man[1] | s2_man[0] | s2_man[3]);
    frac_r = {1'b0, s2_man[N-2:3]} + (MAN_W+1)'(inc);
    e_fin  = s2_exp + EW'(frac_r[MAN_W]);
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    c_n    = {s2_sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
    if (s2_zero)
      c_n = {s2_zsign, {(W-1){1'b0}}};
    else if (s2_cancel)
      c_n = '0;
    else if (s2_exp[EW-1] || s2_exp == '0) begin
      c_n   = {s2_sign, {(W-1){1'b0}}};
      unf_n = 1'b1;
    end else if (e_fin >= EMAX) begin
      c_n   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      bus.c    <= '0;
      bus.ovf  <= 1'b0;
      bus.unf  <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], fire};
      bus.c    <= c_n;
      bus.ovf  <= ovf_n;
      bus.unf  <= unf_n;
    end
  end

  // datapath registers need no reset; their valid bits qualify them
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign   <= a_big ? sa : sb;
      s1_sub    <= eff_sub;
      s1_zero   <= (ea == '0) && (eb == '0);
      s1_zsign  <= sa & sb;
      s1_exp    <= e_big;
      s1_big    <= big_n;
      s1_sml    <= sml_n;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_zsign  <= s1_zsign;
      s2_cancel <= cancel;
      s2_exp    <= e_norm;
      s2_man    <= norm;
    end
  end
endmodule
